pipe_rx_buf: RTL and testbench
==============================

// Module: pipe_rx_buf
// PURPOSE
//  Receive-side buffer at the far end of a regs2d link (long bidirectional register pipeline).
//  Accepts words arriving STAGES cycles late through the forward path and buffers them in a FWFT FIFO.
//  Drives almost_full back through the return path; the threshold covers the round-trip delay, so no word is lost.
//  Sits between the link and a consuming unit, e.g. the sha512crypt core input.
// PARAMETERS
//  WIDTH   32  data word width
//  STAGES  2   register stages of the regs2d link in each direction (>=0)
//  DEPTH   16  FIFO entries; power of 2; must be >= 2*STAGES+4
// PORTS
//  CLK          in   1      clock; single clock domain
//  rst          in   1      asynchronous, active-high reset
//  in_wr        in   1      word valid from the link (exit_in side)
//  in_data      in   WIDTH  word from the link
//  almost_full  out  1      flow control to the link (exit_out side); sender must stop while it sees 1
//  out_valid    out  1      FIFO not empty (FWFT)
//  out_data     out  WIDTH  head word; valid while out_valid=1
//  rd_en        in   1      pop head; ignored when out_valid=0
//  err_overflow out  1      sticky: write arrived while full (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): wr_ptr=rd_ptr=0, count=0, out_valid=0, almost_full=1, err_overflow=0.
//    almost_full=1 during reset keeps the sender idle; it drops on the first CLK edge after release.
//  - Pointers are log2(DEPTH)+1 bits; they wrap modulo 2*DEPTH. count = wr_ptr-rd_ptr, range 0..DEPTH.
//  - Write: on in_wr=1 with count<DEPTH, mem[wr_ptr] <= in_data and wr_ptr++.
//    in_wr=1 with count==DEPTH: word dropped, pointers unchanged, overflow event.
//  - Read: rd_en=1 with count>0 -> rd_ptr++. rd_en=1 with count==0 -> no effect.
//  - Simultaneous write and read: both take effect, count unchanged; allowed when full (the pop frees the slot).
//  - Latency: a word written at edge t is on out_data with out_valid=1 after edge t (same cycle as count>0).
//    Storage read is combinational from distributed RAM.
//  - HEADROOM = 2*STAGES+2 (return path + forward path + almost_full register + margin).
//    almost_full is registered: almost_full <= (count_next > DEPTH-HEADROOM).
//  - The threshold alone prevents loss if the sender honours almost_full as seen at its end of the link.
//  - No internal state machine beyond pointers and count. Reset mid-stream discards buffered words.
//    In-flight link words arriving after reset are accepted normally.
// CONFIGURATION
//  PIPE_RX_BUF_OVF_DETECT_EN defined:
//    err_overflow is set on the first overflow event and held until rst.
//  Not defined:
//    err_overflow tied 0 and the detection logic is omitted. The drop-on-full behaviour is unchanged.
// STRUCTURE
//  - Shared header pipe_link.vh: `define PIPE_LINK_HEADROOM(s) (2*(s)+2) and the clog2 function.
//    The link sender uses the same header.
//  - One sub-module: pipe_rx_ram, a DEPTH x WIDTH distributed RAM.
//    Synchronous write, asynchronous read, no reset on contents.
//  - Pointer, count, flag logic stays in pipe_rx_buf.
// TESTING
//  1. Reset: hold rst 3 cycles -> almost_full=1, out_valid=0, err_overflow=0; one edge after release almost_full=0.
//  2. Single word: in_wr=1, in_data=32'hDEADBEEF for 1 cycle.
//     -> next cycle out_valid=1, out_data=32'hDEADBEEF; rd_en=1 -> out_valid=0.
//  3. Threshold: defaults (STAGES=2, DEPTH=16, HEADROOM=6), no reads, write 1..16 in consecutive cycles.
//     -> almost_full rises after the 11th write (count=11).
//  4. Closed loop: model a regs2d delay of 2 each way; sender stops on the delayed almost_full; consumer stalls 40 cycles.
//     -> no drop, err_overflow=0, output order intact.
//  5. Overflow (macro on): fill 16, write word 17.
//     -> word 17 dropped, err_overflow=1 and stays 1 through reads; after rst it is 0. Macro off: stays 0.
//  6. Full with simultaneous rd_en+in_wr: count stays 16, head advances, new word stored, no overflow.
//     Pointer wrap: 100 random push/pop words -> output matches the input order.

Source files
------------

// File: rtl/pipe_rx_buf_pkg.sv
// Shared constants and helpers for the regs2d receive buffer and its link sender.
// Also holds the round-trip headroom rule so both link ends derive the same threshold.
package pipe_rx_buf_pkg;

    // Return path + forward path + almost_full register + one word of margin.
    function automatic int unsigned pipe_link_headroom(input int unsigned stages);
        return 2 * stages + 2;
    endfunction

    function automatic int unsigned pipe_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_rx_buf_ram.sv
// DEPTH x WIDTH distributed RAM for pipe_rx_buf: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module pipe_rx_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_rx_buf.sv
// Receive-side FWFT buffer at the far end of a regs2d link, with registered almost_full flow control.
// Optional sticky overflow flag is built only when PIPE_RX_BUF_OVF_DETECT_EN is defined.
module pipe_rx_buf
    import pipe_rx_buf_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned DEPTH  = 16
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             in_wr,
    input  logic [WIDTH-1:0] in_data,
    output logic             almost_full,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             rd_en,
    output logic             err_overflow
);

    localparam int unsigned AW       = pipe_clog2(DEPTH);
    localparam int unsigned HEADROOM = pipe_link_headroom(STAGES);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t FULL_CNT  = ptr_t'(DEPTH);
    localparam ptr_t AF_THRESH = ptr_t'(DEPTH - HEADROOM);

    ptr_t r_wr_ptr;
    ptr_t r_rd_ptr;
    logic r_almost_full;

    ptr_t w_count;
    ptr_t w_wr_ptr_nxt;
    ptr_t w_rd_ptr_nxt;
    ptr_t w_count_nxt;
    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;

    always_comb begin
        w_count      = r_wr_ptr - r_rd_ptr;
        w_full       = (w_count == FULL_CNT);
        w_empty      = (w_count == '0);
        w_rd_acc     = rd_en && !w_empty;
        // A pop in the same cycle frees the slot, so a write is accepted even when full.
        w_wr_acc     = in_wr && (!w_full || w_rd_acc);
        w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_wr_acc};
        w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_rd_acc};
        w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_almost_full <= 1'b1;
        end else begin
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_almost_full <= (w_count_nxt > AF_THRESH);
        end
    end

    pipe_rx_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (CLK),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (out_data)
    );

    assign out_valid   = !w_empty;
    assign almost_full = r_almost_full;

`ifdef PIPE_RX_BUF_OVF_DETECT_EN
    logic r_err_overflow;
    logic w_ovf;

    assign w_ovf = in_wr && !w_wr_acc;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_err_overflow <= 1'b0;
        end else if (w_ovf) begin
            r_err_overflow <= 1'b1;
        end
    end

    assign err_overflow = r_err_overflow;
`else
    assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_rx_buf.sv
// Self-checking bench for pipe_rx_buf: directed and random traffic against a queue-based reference model.
module tb_pipe_rx_buf;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned STAGES   = 2;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned HEADROOM = 2 * STAGES + 2;

    logic             CLK = 1'b0;
    logic             rst = 1'b1;
    logic             in_wr = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             almost_full;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             rd_en = 1'b0;
    logic             err_overflow;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    logic [WIDTH-1:0] q[$];
    logic             ovf_m;
    logic             af_m;

    always #5 CLK = ~CLK;

    pipe_rx_buf #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK          (CLK),
        .rst          (rst),
        .in_wr        (in_wr),
        .in_data      (in_data),
        .almost_full  (almost_full),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .rd_en        (rd_en),
        .err_overflow (err_overflow)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ovf_exp();
`ifdef PIPE_RX_BUF_OVF_DETECT_EN
        return ovf_m;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, WIDTH'(out_valid), WIDTH'(q.size() > 0));
        if (q.size() > 0) chk({tag, ".out_data"}, out_data, q[0]);
        chk({tag, ".almost_full"}, WIDTH'(almost_full), WIDTH'(af_m));
        chk({tag, ".err_overflow"}, WIDTH'(err_overflow), WIDTH'(ovf_exp()));
    endtask

    // One clock of traffic: FIFO semantics applied to the queue model, then all outputs compared.
    task automatic step(input string tag, input logic wr, input logic [WIDTH-1:0] d, input logic rd);
        bit rd_a, wr_a;
        in_wr   = wr;
        in_data = d;
        rd_en   = rd;
        rd_a = rd && (q.size() > 0);
        wr_a = wr && ((q.size() < DEPTH) || rd_a);
        if (wr && !wr_a) ovf_m = 1'b1;
        @(posedge CLK);
        #1;
        if (rd_a) void'(q.pop_front());
        if (wr_a) q.push_back(d);
        af_m  = (q.size() > (DEPTH - HEADROOM));
        in_wr = 1'b0;
        rd_en = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        rst   = 1'b1;
        in_wr = 1'b0;
        rd_en = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        af_m  = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.almost_full", WIDTH'(almost_full), WIDTH'(1));
        chk("rst.out_valid", WIDTH'(out_valid), WIDTH'(0));
        chk("rst.err_overflow", WIDTH'(err_overflow), WIDTH'(0));
        rst = 1'b0;
        step("post_rst", 1'b0, '0, 1'b0);
        chk("post_rst.af_low", WIDTH'(almost_full), WIDTH'(0));
    endtask

    initial begin
        logic             fwd_v  [STAGES];
        logic [WIDTH-1:0] fwd_d  [STAGES];
        logic             af_ret [STAGES];
        int unsigned      sent, rcv;
        logic [WIDTH-1:0] exp_next;

        // Reset behaviour
        do_reset();

        // Single word, visible the cycle after the write
        step("single_wr", 1'b1, 32'hDEADBEEF, 1'b0);
        chk("single.valid", WIDTH'(out_valid), WIDTH'(1));
        chk("single.data", out_data, 32'hDEADBEEF);
        step("single_rd", 1'b0, '0, 1'b1);
        chk("single.empty", WIDTH'(out_valid), WIDTH'(0));
        step("rd_empty", 1'b0, '0, 1'b1);

        // Threshold: almost_full rises with the 11th word
        for (int i = 1; i <= 16; i++) begin
            step("fill", 1'b1, WIDTH'(i), 1'b0);
            chk("fill.af_threshold", WIDTH'(almost_full), WIDTH'(i >= 11));
        end

        // Overflow: word 17 is dropped
        step("ovf_wr", 1'b1, 32'd17, 1'b0);
        chk("ovf.head", out_data, 32'd1);

        // Full with simultaneous read and write: head advances, word stored
        step("full_rdwr", 1'b1, 32'hF00D0001, 1'b1);
        chk("full_rdwr.head", out_data, 32'd2);
        chk("full_rdwr.af", WIDTH'(almost_full), WIDTH'(1));

        for (int i = 0; i < 16; i++) step("drain", 1'b0, '0, 1'b1);
        chk("drain.empty", WIDTH'(out_valid), WIDTH'(0));
        step("drain_sticky", 1'b0, '0, 1'b0);

        do_reset();

        // Closed loop through a modelled regs2d link; consumer stalls for 40 cycles
        for (int k = 0; k < STAGES; k++) begin
            fwd_v[k]  = 1'b0;
            fwd_d[k]  = '0;
            af_ret[k] = 1'b1;
        end
        sent     = 0;
        rcv      = 0;
        exp_next = 32'hA5000000;
        for (int cyc = 0; cyc < 3000 && rcv < 60; cyc++) begin
            bit send, rd;
            send = !af_ret[STAGES-1] && (sent < 60);
            rd   = (cyc >= 40) && ($urandom_range(0, 3) != 0);
            if (rd && q.size() > 0) begin
                chk("loop.order", out_data, exp_next);
                exp_next++;
                rcv++;
            end
            step("loop", fwd_v[STAGES-1], fwd_d[STAGES-1], rd);
            for (int k = STAGES - 1; k > 0; k--) begin
                fwd_v[k]  = fwd_v[k-1];
                fwd_d[k]  = fwd_d[k-1];
                af_ret[k] = af_ret[k-1];
            end
            fwd_v[0]  = send;
            fwd_d[0]  = 32'hA5000000 + WIDTH'(sent);
            af_ret[0] = almost_full;
            if (send) sent++;
        end
        chk("loop.received", WIDTH'(rcv), WIDTH'(60));
        chk("loop.no_ovf", WIDTH'(err_overflow), WIDTH'(0));

        do_reset();

        // Random push/pop across several pointer wraps
        sent = 0;
        for (int cyc = 0; cyc < 2000 && sent < 100; cyc++) begin
            bit wr, rd;
            wr = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 1) == 1);
            step("rand", wr, $urandom, rd);
            if (wr) sent++;
        end
        for (int i = 0; i < DEPTH + 1; i++) step("rand_drain", 1'b0, '0, 1'b1);
        chk("rand.empty", WIDTH'(out_valid), WIDTH'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
